// File: rtl/fifo_pkg.sv
// Shared constants and word type for the synchronous FIFO and its fifo_in / fifo_out agents.
package fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Storage is intentionally not reset; the pointers define what is valid.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_vr.sv
// Synchronous valid/ready FIFO with first-word-fall-through output and occupancy level.
module fifo_sync_vr
    import fifo_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_vld,
    output logic              data_in_rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_vld,
    input  logic              data_out_rdy,
    output logic [CNT_W-1:0]  level
);

    localparam int AW = CNT_W - 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign data_in_rdy  = !full;
    assign data_out_vld = !empty;
    assign level        = wr_ptr - rd_ptr;

    assign push = data_in_vld && data_in_rdy;
    assign pop  = data_out_vld && data_out_rdy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && rstn),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (data_out)
    );

    a_level_max: assert property (@(posedge clk) disable iff (!rstn)
        level <= CNT_W'(DEPTH));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
        (data_out_vld && !data_out_rdy) |=> (data_out_vld && $stable(data_out)));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        !(push && full));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && empty));

endmodule

// File: tb/tb_fifo_sync_vr.sv
// Self-checking bench for fifo_sync_vr: directed scenarios plus random traffic against a queue model.
module tb_fifo_sync_vr;
    import fifo_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    fifo_data_t       data_in = '0;
    logic             data_in_vld = 1'b0;
    logic             data_in_rdy;
    fifo_data_t       data_out;
    logic             data_out_vld;
    logic             data_out_rdy = 1'b0;
    logic [CNT_W-1:0] level;

    int n_total = 0;
    int n_bad   = 0;

    fifo_data_t q[$];

    fifo_sync_vr #(.DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_in_rdy  (data_in_rdy),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("level", 32'(level), 32'(q.size()));
        chk("out_vld", 32'(data_out_vld), 32'(q.size() != 0));
        chk("in_rdy", 32'(data_in_rdy), 32'(q.size() < DEPTH));
        if (q.size() != 0) begin
            chk("data_out", 32'(data_out), 32'(q[0]));
        end
    endtask

    // Apply inputs, clock once, advance the model by the handshake rules, then compare.
    task automatic step(input logic r, input logic iv, input fifo_data_t d, input logic ordy);
        bit do_push;
        bit do_pop;
        rstn         = r;
        data_in_vld  = iv;
        data_in      = d;
        data_out_rdy = ordy;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (!r) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        #1;
        check_model();
    endtask

    initial begin
        fifo_data_t exp_drain[$];

        // reset then idle, consumer ready on an empty FIFO
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
        chk("idle_level", 32'(level), 32'd0);

        // single word
        step(1'b1, 1'b1, 16'hA5A5, 1'b0);
        chk("single_data", 32'(data_out), 32'h0000A5A5);
        chk("single_level", 32'(level), 32'd1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("single_popped", 32'(data_out_vld), 32'd0);

        // fill to full, ninth push ignored
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, fifo_data_t'(i), 1'b0);
        chk("full_rdy", 32'(data_in_rdy), 32'd0);
        step(1'b1, 1'b1, 16'h0009, 1'b0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_head", 32'(data_out), 32'd1);

        // full with push+pop: only the pop happens
        step(1'b1, 1'b1, 16'h00FF, 1'b1);
        chk("fullpp_level", 32'(level), 32'd7);
        chk("fullpp_rdy", 32'(data_in_rdy), 32'd1);
        step(1'b1, 1'b1, 16'h00FF, 1'b0);
        chk("fullpp_refill", 32'(level), 32'd8);

        for (int i = 2; i <= 8; i++) exp_drain.push_back(fifo_data_t'(i));
        exp_drain.push_back(16'h00FF);
        foreach (exp_drain[i]) begin
            chk("drain_order", 32'(data_out), 32'(exp_drain[i]));
            step(1'b1, 1'b0, '0, 1'b1);
        end
        chk("drain_empty", 32'(data_out_vld), 32'd0);

        // streaming through several pointer wraps
        for (int i = 0; i < 40; i++) begin
            if (i > 0) chk("stream_data", 32'(data_out), 32'(16'h0100 + i - 1));
            step(1'b1, 1'b1, fifo_data_t'(16'h0100 + i), 1'b1);
            chk("stream_level", 32'(level), 32'd1);
        end
        chk("stream_last", 32'(data_out), 32'h00000127);
        step(1'b1, 1'b0, '0, 1'b1);

        // reset mid-operation wins over concurrent push and pop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, fifo_data_t'(16'h0200 + i), 1'b0);
        chk("mid_level", 32'(level), 32'd5);
        step(1'b0, 1'b1, 16'h0300, 1'b1);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_vld", 32'(data_out_vld), 32'd0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b0);
        chk("mid_first_out", 32'(data_out), 32'h0000BEEF);
        step(1'b1, 1'b0, '0, 1'b1);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 60),
                 fifo_data_t'($urandom),
                 ($urandom_range(0, 99) < 50));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
